// File: rtl/frame_serializer.sv
// Serializes a 128-bit block as SYNC_WORD (MSB first) + data (LSB first) + optional CRC-8.
// Define FRAME_SERIALIZER_CRC8_EN to append a CRC-8 (poly 0x07) field after the data.
module frame_serializer #(
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] par_in,
  input  logic         data_valid,
  output logic         ready,
  output logic         tx_bit,
  output logic         tx_valid,
  output logic         frame_done,
  output logic         overrun
);

`ifdef FRAME_SERIALIZER_CRC8_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, CRC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t         r_state, w_next;
  logic [7:0]     r_cnt;
  logic [127:0]   r_buf;
  logic           r_ovr;
  logic           w_ready, w_tx_bit, w_tx_valid, w_done;

`ifdef FRAME_SERIALIZER_CRC8_EN
  logic [7:0]     r_crc;
  logic [7:0]     w_crc_next;

  // Serial CRC-8 over data bits in the order they leave the wire.
  assign w_crc_next = {r_crc[6:0], 1'b0} ^ ({8{r_crc[7] ^ r_buf[0]}} & 8'h07);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_bit   = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (data_valid) w_next = SYNC;
      end
      SYNC: begin
        w_tx_valid = 1'b1;
        w_tx_bit   = SYNC_WORD[3'd7 - r_cnt[2:0]];
        if (r_cnt == 8'd7) w_next = DATA;
      end
      DATA: begin
        w_tx_valid = 1'b1;
        w_tx_bit   = r_buf[0];
        if (r_cnt == 8'd127) begin
`ifdef FRAME_SERIALIZER_CRC8_EN
          w_next = CRC;
`else
          w_next = IDLE;
          w_done = 1'b1;
`endif
        end
      end
`ifdef FRAME_SERIALIZER_CRC8_EN
      CRC: begin
        w_tx_valid = 1'b1;
        w_tx_bit   = r_crc[3'd7 - r_cnt[2:0]];
        if (r_cnt == 8'd7) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Datapath: buffer, per-state bit counter, sticky overrun, CRC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_buf <= '0;
      r_ovr <= 1'b0;
`ifdef FRAME_SERIALIZER_CRC8_EN
      r_crc <= 8'd0;
`endif
    end else begin
      if (data_valid && r_state != IDLE) r_ovr <= 1'b1;
      if (r_state == IDLE) begin
        if (data_valid) begin
          r_buf <= par_in;
          r_cnt <= 8'd0;
`ifdef FRAME_SERIALIZER_CRC8_EN
          r_crc <= 8'd0;
`endif
        end
      end else if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == DATA) begin
        r_buf <= {1'b0, r_buf[127:1]};
`ifdef FRAME_SERIALIZER_CRC8_EN
        r_crc <= w_crc_next;
`endif
      end
    end
  end

  assign ready      = w_ready;
  assign tx_bit     = w_tx_bit;
  assign tx_valid   = w_tx_valid;
  assign frame_done = w_done;
  assign overrun    = r_ovr;

endmodule
